// File: rtl/neuron_mac_accum.sv
// Floating-point multiply-accumulate for one neuron (float_24_8 operands).
// Two-stage pipeline: registered product, then single-cycle accumulate with per-vector emit.
module neuron_mac_accum #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      dataIn,
    input  logic [31:0]      weightIn,
    input  logic             inValid,
    input  logic             inLast,
    output logic [31:0]      dataOutPre_0,
    output logic             outValid,
    output logic [CNT_W-1:0] outCount
);

    localparam logic [30:0] MAX_MAG = 31'h7F7FFFFF;

    function automatic logic [4:0] lead_zeros(input logic [23:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) begin
                    found = 1'b1;
                end else begin
                    n = n + 5'd1;
                end
            end
        end
        return n;
    endfunction

    logic [47:0]      w_prod_full;
    logic             w_prod_top;
    logic [9:0]       w_mul_exp_biased;
    logic [31:0]      w_mul_res;
    logic             w_unused_prod_lo;

    logic [31:0]      r_prod;
    logic             r_prod_valid;
    logic             r_prod_last;
    logic [31:0]      r_acc;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_out_data;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_out_count;

    // Multiplier: mantissa product, exponent sum (still carrying one bias), flush/saturate.
    always_comb begin
        w_prod_full      = 48'({1'b1, dataIn[22:0]}) * 48'({1'b1, weightIn[22:0]});
        w_prod_top       = w_prod_full[47];
        w_mul_exp_biased = {2'b00, dataIn[30:23]} + {2'b00, weightIn[30:23]} + {9'd0, w_prod_top};
        w_unused_prod_lo = ^w_prod_full[22:0];
        w_mul_res        = 32'h0000_0000;
        if ((dataIn[30:23] == 8'd0) || (weightIn[30:23] == 8'd0)) begin
            w_mul_res = 32'h0000_0000;
        end else if (w_mul_exp_biased <= 10'd127) begin
            w_mul_res = 32'h0000_0000;
        end else if (w_mul_exp_biased >= 10'd382) begin
            w_mul_res = {dataIn[31] ^ weightIn[31], MAX_MAG};
        end else begin
            w_mul_res = {dataIn[31] ^ weightIn[31], 8'(w_mul_exp_biased - 10'd127),
                         w_prod_top ? w_prod_full[46:24] : w_prod_full[45:23]};
        end
    end

    logic [31:0] w_big;
    logic [31:0] w_small;
    logic [7:0]  w_exp_diff;
    logic [23:0] w_man_big;
    logic [23:0] w_man_small;
    logic [24:0] w_mag_sum;
    logic [23:0] w_mag_diff;
    logic [4:0]  w_lz;
    logic [23:0] w_norm;
    logic [8:0]  w_exp_inc;
    logic [31:0] w_sum;

    // Accumulator adder: align smaller magnitude, add or subtract, renormalise.
    always_comb begin
        if (r_acc[30:0] >= r_prod[30:0]) begin
            w_big   = r_acc;
            w_small = r_prod;
        end else begin
            w_big   = r_prod;
            w_small = r_acc;
        end
        w_exp_diff  = w_big[30:23] - w_small[30:23];
        w_man_big   = {1'b1, w_big[22:0]};
        w_man_small = (w_exp_diff > 8'd24) ? 24'd0 : ({1'b1, w_small[22:0]} >> w_exp_diff);
        w_mag_sum   = {1'b0, w_man_big} + {1'b0, w_man_small};
        w_mag_diff  = w_man_big - w_man_small;
        w_lz        = lead_zeros(w_mag_diff);
        w_norm      = w_mag_diff << w_lz;
        w_exp_inc   = {1'b0, w_big[30:23]} + 9'd1;
        w_sum       = 32'h0000_0000;
        if (r_acc[30:23] == 8'd0) begin
            w_sum = r_prod;
        end else if (r_prod[30:23] == 8'd0) begin
            w_sum = r_acc;
        end else if (w_big[31] == w_small[31]) begin
            if (w_mag_sum[24]) begin
                if (w_exp_inc >= 9'd255) begin
                    w_sum = {w_big[31], MAX_MAG};
                end else begin
                    w_sum = {w_big[31], w_exp_inc[7:0], w_mag_sum[23:1]};
                end
            end else begin
                w_sum = {w_big[31], w_big[30:23], w_mag_sum[22:0]};
            end
        end else if (w_mag_diff == 24'd0) begin
            w_sum = 32'h0000_0000;
        end else if ({3'b000, w_lz} >= w_big[30:23]) begin
            w_sum = 32'h0000_0000;
        end else begin
            w_sum = {w_big[31], w_big[30:23] - {3'b000, w_lz}, w_norm[22:0]};
        end
    end

    // Stage 1 register: product and its qualifiers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prod       <= 32'h0000_0000;
            r_prod_valid <= 1'b0;
            r_prod_last  <= 1'b0;
        end else begin
            r_prod       <= w_mul_res;
            r_prod_valid <= inValid;
            r_prod_last  <= inValid & inLast;
        end
    end

    // Stage 2 register: accumulate, and on the last product emit and clear for the next vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= 32'h0000_0000;
            r_count     <= {CNT_W{1'b0}};
            r_out_data  <= 32'h0000_0000;
            r_out_valid <= 1'b0;
            r_out_count <= {CNT_W{1'b0}};
        end else begin
            r_out_valid <= 1'b0;
            if (r_prod_valid) begin
                if (r_prod_last) begin
                    r_out_data  <= w_sum;
                    r_out_valid <= 1'b1;
                    r_out_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                    r_acc       <= 32'h0000_0000;
                    r_count     <= {CNT_W{1'b0}};
                end else begin
                    r_acc       <= w_sum;
                    r_count     <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign dataOutPre_0 = r_out_data;
    assign outValid     = r_out_valid;
    assign outCount     = r_out_count;

endmodule

// File: tb/tb_neuron_mac_accum.sv
// Bench for neuron_mac_accum: integer-arithmetic float model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_neuron_mac_accum;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   dataIn, weightIn;
    logic          inValid, inLast;
    logic [31:0]   dataOutPre_0;
    logic          outValid;
    logic [CW-1:0] outCount;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    neuron_mac_accum #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .dataIn(dataIn), .weightIn(weightIn),
        .inValid(inValid), .inLast(inLast), .dataOutPre_0(dataOutPre_0),
        .outValid(outValid), .outCount(outCount)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_pack(input logic s, input int e, input longint mag);
        if (e <= 0) return 32'h0000_0000;
        if (e >= 255) return {s, 31'h7F7FFFFF};
        return {s, e[7:0], mag[22:0]};
    endfunction

    function automatic logic [31:0] m_mul(input logic [31:0] a, input logic [31:0] b);
        longint ma, mb, m;
        int e;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'h0000_0000;
        ma = {1'b1, a[22:0]};
        mb = {1'b1, b[22:0]};
        m  = (ma * mb) >>> 23;
        e  = int'(a[30:23]) + int'(b[30:23]) - 127;
        while (m >= 64'sd16777216) begin
            m = m >>> 1;
            e++;
        end
        return m_pack(a[31] ^ b[31], e, m);
    endfunction

    // Signed integer sum of the two aligned significands, then renormalise by loops.
    function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] big, sml;
        longint mbig, msm, v, mag;
        int d, e;
        if (a[30:23] == 8'd0) return b;
        if (b[30:23] == 8'd0) return a;
        if (a[30:0] >= b[30:0]) begin big = a; sml = b; end
        else begin big = b; sml = a; end
        d    = int'(big[30:23]) - int'(sml[30:23]);
        mbig = {1'b1, big[22:0]};
        msm  = {1'b1, sml[22:0]};
        msm  = (d > 24) ? 64'sd0 : (msm >>> d);
        v    = (big[31] ? -mbig : mbig) + (sml[31] ? -msm : msm);
        if (v == 64'sd0) return 32'h0000_0000;
        mag  = (v < 64'sd0) ? -v : v;
        e    = int'(big[30:23]);
        while (mag >= 64'sd16777216) begin mag = mag >>> 1; e++; end
        while (mag < 64'sd8388608)   begin mag = mag <<< 1; e--; end
        return m_pack(v < 64'sd0, e, mag);
    endfunction

    typedef struct {
        logic [31:0]   data;
        logic [CW-1:0] cnt;
        int            due;
    } pend_t;

    pend_t         pend_q[$];
    pend_t         m_t;
    logic [31:0]   m_acc = 32'h0;
    logic [31:0]   m_sum;
    int            m_cnt = 0;
    int            cyc = 0;
    logic          exp_valid = 1'b0;
    logic          exp_rst = 1'b0;
    logic [31:0]   exp_data = 32'h0;
    logic [CW-1:0] exp_cnt = '0;

    // Model: what the outputs must be just after each rising edge.
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            pend_q.delete();
            m_acc     = 32'h0;
            m_cnt     = 0;
            exp_valid = 1'b0;
            exp_rst   = 1'b1;
            exp_data  = 32'h0;
            exp_cnt   = '0;
        end else begin
            exp_rst   = 1'b0;
            exp_valid = 1'b0;
            if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                m_t       = pend_q.pop_front();
                exp_valid = 1'b1;
                exp_data  = m_t.data;
                exp_cnt   = m_t.cnt;
            end
            if (inValid) begin
                m_sum = m_add(m_acc, m_mul(dataIn, weightIn));
                m_cnt++;
                if (inLast) begin
                    m_t.data = m_sum;
                    m_t.cnt  = m_cnt[CW-1:0];
                    m_t.due  = cyc + 1;
                    pend_q.push_back(m_t);
                    m_acc = 32'h0;
                    m_cnt = 0;
                end else begin
                    m_acc = m_sum;
                end
            end
        end
    end

    logic [31:0] obs_q[$];

    // Compare against the model every cycle, away from the active edge; log emitted results.
    always @(negedge clk) begin
        if (cyc > 0) begin
            check32("outValid", {31'd0, outValid}, {31'd0, exp_valid});
            check32("dataOutPre_0", dataOutPre_0, exp_data);
            if (exp_valid || exp_rst)
                check32("outCount", {{(32-CW){1'b0}}, outCount}, {{(32-CW){1'b0}}, exp_cnt});
        end
        if (outValid) begin
            obs_q.push_back(dataOutPre_0);
            obs_q.push_back({{(32-CW){1'b0}}, outCount});
        end
    end

    task automatic send(input logic v, input logic l, input logic [31:0] d, input logic [31:0] w);
        inValid  = v;
        inLast   = l;
        dataIn   = d;
        weightIn = w;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [31:0] d, input int c);
        for (int i = 0; i < 6 && obs_q.size() == 0; i++) send(1'b0, 1'b0, 32'h0, 32'h0);
        if (obs_q.size() < 2) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no output strobe within 6 cycles, expected %08h", name, d);
        end else begin
            check32({name, "_data"}, obs_q.pop_front(), d);
            check32({name, "_count"}, obs_q.pop_front(), 32'(c));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        inValid = 1'b0; inLast = 1'b0; dataIn = 32'h0; weightIn = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check32("rst_data", dataOutPre_0, 32'h0000_0000);
        check32("rst_valid", {31'd0, outValid}, 32'h0);
        check32("rst_count", {{(32-CW){1'b0}}, outCount}, 32'h0);

        check32("model_mul_2x3", m_mul(32'h40000000, 32'h40400000), 32'h40C00000);
        check32("model_add_3_1", m_add(32'h40400000, 32'h3F800000), 32'h40800000);
        check32("model_add_cancel", m_add(32'h40000000, 32'hC0000000), 32'h00000000);
        check32("model_mul_sat", m_mul(32'h71800000, 32'h71800000), 32'h7F7FFFFF);

        send(1'b1, 1'b1, 32'h40000000, 32'h40400000);
        expect_out("single_pair", 32'h40C00000, 1);

        send(1'b1, 1'b0, 32'h3F800000, 32'h3F800000);
        send(1'b1, 1'b0, 32'h3F800000, 32'h3F800000);
        send(1'b0, 1'b1, 32'h40000000, 32'h40000000);
        send(1'b1, 1'b0, 32'h3F800000, 32'h3F800000);
        send(1'b1, 1'b1, 32'h3F800000, 32'h3F800000);
        expect_out("four_ones", 32'h40800000, 4);

        send(1'b1, 1'b0, 32'h40000000, 32'h3F800000);
        send(1'b1, 1'b1, 32'hBF800000, 32'h40000000);
        expect_out("cancel", 32'h00000000, 2);

        send(1'b1, 1'b1, 32'h3F800000, 32'h3F000000);
        send(1'b1, 1'b1, 32'h40000000, 32'h40000000);
        expect_out("b2b_first", 32'h3F000000, 1);
        expect_out("b2b_second", 32'h40800000, 1);

        send(1'b1, 1'b0, 32'h3F800000, 32'h3F800000);
        send(1'b1, 1'b0, 32'h3F800000, 32'h3F800000);
        reset = 1'b1;
        send(1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        send(1'b1, 1'b1, 32'h3F800000, 32'h3F800000);
        expect_out("after_reset", 32'h3F800000, 1);

        send(1'b1, 1'b1, 32'h00000000, 32'h40400000);
        expect_out("zero_operand", 32'h00000000, 1);
        send(1'b1, 1'b1, 32'h71800000, 32'h71800000);
        expect_out("saturate", 32'h7F7FFFFF, 1);
        send(1'b1, 1'b1, 32'h0D800000, 32'h0D800000);
        expect_out("underflow", 32'h00000000, 1);

        send(1'b1, 1'b0, 32'h40400000, 32'h3F800000);
        send(1'b1, 1'b0, 32'hBF800000, 32'h3FA00000);
        send(1'b1, 1'b1, 32'h3F000000, 32'h3E800000);
        expect_out("mixed_sign", 32'h3FF00000, 3);

        for (int i = 0; i < 17; i++) send(1'b1, (i == 16), 32'h3F800000, 32'h3F800000);
        expect_out("count_wrap", 32'h41880000, 1);

        repeat (4) send(1'b0, 1'b0, 32'h0, 32'h0);
        check32("no_extra_outputs", 32'(obs_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/neuron_mac_accum.md
Name: neuron_mac_accum

Overview:
- Upstream neighbour of the sigmoid activation stage: floating-point multiply-accumulate for one neuron.
- Takes a stream of (data, weight) float_24_8 pairs, multiplies each pair and accumulates the products.
- On the last pair of a vector, presents the sum as dataOutPre_0 with a one-cycle valid strobe. The sigmoid stage then consumes it directly.
- Fully pipelined: accepts one pair per cycle, and vectors may follow each other back-to-back.

Parameters:
- CNT_W, 16, width of the per-vector element counter.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- dataIn  input  32  float_24_8 activation {sgn[31], exp[30:23], man[22:0]}
- weightIn  input  32  float_24_8 weight
- inValid  input  1  dataIn/weightIn valid this cycle
- inLast  input  1  final pair of the current vector; qualified by inValid
- dataOutPre_0  output  32  float_24_8 accumulated sum, feeds sigmoid
- outValid  output  1  one-cycle strobe, dataOutPre_0 valid
- outCount  output  CNT_W  number of pairs in the emitted vector; valid with outValid

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk.
- Reset values: dataOutPre_0=0, outValid=0, outCount=0, accumulator=0, element counter=0, all pipeline valids=0.
- Number format:
  - bias 127; exp==0 means zero (no denormals); no inf/NaN handling.
  - Any result with exp<=0 flushes to 0x00000000.
  - Any result with exp>=255 saturates to sign|0x7F7FFFFF.
  - All rounding is truncation.
  - Zero results always have sgn=0.
- Stage 1, multiply, registered at t+1 for a pair accepted at t:
  - sgn = sa^sb.
  - 48-bit product of {1,manA}*{1,manB}.
  - If bit47 is set: man = p[46:24], exp = ea+eb-126; else man = p[45:23], exp = ea+eb-127.
  - Either operand zero gives a zero product.
  - prodValid and prodLast are registered from inValid and inLast.
- Stage 2, accumulate, registered at t+2:
  - sum = acc + prod, a single-cycle float add.
  - Align the smaller-magnitude operand by right-shifting by the exponent difference; a difference >24 contributes nothing.
  - Equal signs: add, normalise on carry (exp+1, shift right 1).
  - Unequal signs: subtract the smaller magnitude from the larger; result takes the larger operand's sign; renormalise via leading-one priority encoder (exp-=lz).
  - Exact cancellation gives 0x00000000.
  - Zero operands pass the other operand through unchanged.
- When prodValid & !prodLast: acc <= sum, count <= count+1.
- When prodValid & prodLast:
  - dataOutPre_0 <= sum, outValid <= 1, outCount <= count+1.
  - acc <= 0, count <= 0 on the same edge, so the next vector's first product may arrive the following cycle.
- outValid is high for exactly one cycle per vector. Latency from the inLast pair to outValid is 2 cycles.
- dataOutPre_0 holds its value until the next outValid.
- inValid=0 cycles (bubbles) inside a vector are allowed; the accumulator holds.
- inLast without inValid is ignored.
- A single-pair vector (inValid & inLast on the first pair) emits just that product.
- Counter overflow: outCount wraps modulo 2^CNT_W; the sum is unaffected.
- Reset mid-vector:
  - The partial sum and all in-flight products are discarded.
  - outValid stays 0 for that vector.
  - The first pair after reset deasserts starts a fresh vector.

Test Plan:
- Single pair: 0x40000000 * 0x40400000 with inLast → outValid 2 cycles later, dataOutPre_0=0x40C00000 (6.0), outCount=1.
- Four pairs of 0x3F800000*0x3F800000, last on the 4th, with a bubble between pairs 2 and 3 → dataOutPre_0=0x40800000 (4.0), outCount=4, single outValid pulse.
- Cancellation: 0x40000000*0x3F800000 then 0xBF800000*0x40000000 (last) → dataOutPre_0=0x00000000.
- Back-to-back vectors on consecutive cycles:
  - first vector: 0x3F800000*0x3F000000, last;
  - second vector: 0x40000000*0x40000000, last;
  - expected: outValid on two consecutive cycles with 0x3F000000 then 0x40800000.
- Reset mid-vector: two pairs of 1.0*1.0, assert reset 1 cycle, then 1.0*1.0 last → no output for the aborted vector, then 0x3F800000 with outCount=1.
- Edge cases:
  - 0x00000000*0x40400000 last → 0x00000000.
  - 0x71800000*0x71800000 (2^100 squared) last → 0x7F7FFFFF.
  - 0x0D800000*0x0D800000 last → 0x00000000 (underflow flush).
